// File: rtl/conc_stim_pkg.sv
// conc_stim_pkg: shared state type, word layout and default sizing for the stimulus sequencer.
package conc_stim_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} stim_state_t;
    localparam int STIM_W    = 32;
    localparam int OBS_BIT   = 31;
    localparam int DEPTH_DEF = 501;
    localparam int AW_DEF    = 9;
endpackage

// File: rtl/conc_stim_ram.sv
// conc_stim_ram: DEPTH x 32 stimulus store, one write port and one synchronous read port, no reset.
module conc_stim_ram import conc_stim_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [STIM_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [STIM_W-1:0] o_rdata
);
    logic [STIM_W-1:0] r_mem [DEPTH];
    logic [STIM_W-1:0] r_rdata;
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/conc_stim_sequencer.sv
// conc_stim_sequencer: loads a stimulus program over valid/ready and replays one word per clock
// as {obs, datai}, optionally looping, with an issued-word counter for trace correlation.
module conc_stim_sequencer import conc_stim_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [STIM_W-1:0] load_data,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [30:0]       datai,
    output logic              obs,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       issued
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    stim_state_t       r_state, w_state_nxt;
    logic [AW:0]       r_count, w_count_nxt;
    logic [AW-1:0]     r_rd_ptr, w_rd_nxt;
    logic [STIM_W-1:0] w_q;
    logic [30:0]       r_datai;
    logic [31:0]       r_issued;
    logic              r_obs, r_valid;
    logic              w_idle, w_go, w_last, w_issue, w_wr;

    assign w_idle     = r_state != RUN;
    assign w_go       = w_idle && start && !clear && r_count != '0;
    assign w_last     = {1'b0, r_rd_ptr} == r_count - 1'b1;
    assign w_issue    = r_state == RUN && !stop;
    assign load_ready = w_idle && !start && r_count < DEPTH_C;
    assign w_wr       = load_valid && load_ready && !clear;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_rd_nxt    = r_rd_ptr;
        if (w_idle) begin
            if (clear) begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end else if (w_go) begin
                w_state_nxt = RUN;
                w_rd_nxt    = '0;
            end else if (w_wr) begin
                w_count_nxt = r_count + 1'b1;
            end
        end else if (stop) begin
            w_state_nxt = IDLE;
        end else if (w_last) begin
            w_state_nxt = loop_en ? RUN : DONE;
            w_rd_nxt    = '0;
        end else begin
            w_rd_nxt = r_rd_ptr + 1'b1;
        end
    end

    // Read address comes from the next-state pointer so the word is ready in the cycle it is issued.
    conc_stim_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock   (clock),
        .i_we    (w_wr),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata (load_data),
        .i_raddr (w_rd_nxt),
        .o_rdata (w_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_datai  <= '0;
            r_obs    <= 1'b0;
            r_valid  <= 1'b0;
            r_issued <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_datai  <= w_issue ? w_q[30:0] : '0;
            r_obs    <= w_issue && w_q[OBS_BIT];
            r_valid  <= w_issue;
            r_issued <= w_go ? '0 : w_issue ? r_issued + 1'b1 : r_issued;
        end
    end

    assign datai      = r_datai;
    assign obs        = r_obs;
    assign stim_valid = r_valid;
    assign issued     = r_issued;
    assign busy       = r_state == RUN;
    // The last word is still on the outputs the cycle the FSM enters DONE; done waits for it to drain.
    assign done       = r_state == DONE && !r_valid;
endmodule

// File: tb/tb_conc_stim_sequencer.sv
// tb_conc_stim_sequencer: directed vectors with hand-computed expectations for conc_stim_sequencer.
module tb_conc_stim_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [30:0] datai;
    logic        obs, stim_valid, busy, done;
    logic [31:0] issued;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] prog3 [3] = '{32'h8000_0001, 32'h0000_0002, 32'h7FFF_FFFF};

    conc_stim_sequencer dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .clear(clear), .start(start), .stop(stop), .loop_en(loop_en),
        .datai(datai), .obs(obs), .stim_valid(stim_valid), .busy(busy), .done(done), .issued(issued)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    function automatic logic [31:0] wgen(input int i);
        return {i[0], 31'(i * 3 + 5)};
    endfunction

    // {stim_valid, obs, datai}
    function automatic logic [63:0] outv;
        return {32'd0, stim_valid, obs, datai};
    endfunction

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out", {stim_valid, obs, datai, busy, done, load_ready}, {1'b0, 1'b0, 31'd0, 1'b0, 1'b0, 1'b1});
        chk("rst_issued", issued, 0);

        for (int i = 0; i < 3; i++) load_word(prog3[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {busy, stim_valid}, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("w3_word", outv(), {32'd0, 1'b1, prog3[k]});
        end
        chk("w3_done_wait", done, 0);
        tick();
        chk("w3_end", {stim_valid, obs, datai, busy, done}, {1'b0, 1'b0, 31'd0, 1'b0, 1'b1});
        chk("w3_issued", issued, 3);

        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("loop_word", outv(), {32'd0, 1'b1, prog3[k % 3]});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("loop_stop", {stim_valid, busy, done}, 3'b000);
        chk("loop_issued", issued, 7);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ready", {load_ready, busy}, 2'b10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_empty", {busy, done}, 2'b00);
        tick();
        chk("start_empty_v", stim_valid, 0);

        load_word(32'h0000_00AA);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("one_word", outv(), {32'd0, 1'b1, 32'h0000_00AA});
        tick();
        chk("one_done", done, 1);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("clrstart_idle", {busy, done}, 2'b00);
        tick();
        chk("clrstart_nov", stim_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clrstart_empty", busy, 0);

        load_word(32'h8000_0011);
        load_word(32'h0000_0022);
        load_valid = 1'b1;
        load_data = 32'h1234_5678;
        start = 1'b1;
        #1;
        chk("ldst_ready", load_ready, 0);
        tick();
        load_valid = 1'b0;
        start = 1'b0;
        chk("ldst_busy", busy, 1);
        tick();
        chk("ldst_w0", outv(), {32'd0, 1'b1, 32'h8000_0011});
        tick();
        chk("ldst_w1", outv(), {32'd0, 1'b1, 32'h0000_0022});
        tick();
        chk("ldst_end", {stim_valid, done}, 2'b01);
        chk("ldst_issued", issued, 2);

        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("arst_w1", outv(), {32'd0, 1'b1, 32'h0000_0022});
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", {stim_valid, obs, datai, busy}, {1'b0, 1'b0, 31'd0, 1'b0});
        tick();
        reset = 1'b0;
        loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arst_nostart", busy, 0);
        tick();
        chk("arst_nov", stim_valid, 0);

        for (int i = 0; i < 501; i++) begin
            load_valid = 1'b1;
            load_data  = wgen(i);
            #1;
            if (i == 500) chk("full_ready_last", load_ready, 1);
            tick();
        end
        load_valid = 1'b0;
        chk("full_ready", load_ready, 0);
        load_word(32'hDEAD_BEEF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 501; k++) begin
            tick();
            chk("full_word", outv(), {32'd0, 1'b1, wgen(k)});
        end
        tick();
        chk("full_end", {stim_valid, busy, done}, 3'b001);
        chk("full_issued", issued, 501);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/conc_stim_sequencer.md
# conc_stim_sequencer

Synthesizable stimulus sequencer that replaces the behavioural program-counter loop in the concolic benches. It stores a stimulus program of 32-bit words and replays one word per clock into the design under test: bit 31 drives the observation strobe `obs` and bits 30:0 drive `datai`. It sits directly upstream of the DUT top (e.g. `b14`). It is loaded word-by-word through a valid/ready port and reports the issued-word count for trace correlation.

## Interface
Parameters:
- `DEPTH`, 501: stimulus words stored.
- `AW`, 9: address width, ≥ clog2(DEPTH).

Ports:
- `clock`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `load_valid`  in  1  load word present.
- `load_ready`  out  1  load word accepted when high with `load_valid`.
- `load_data`  in  32  stimulus word (bit 31 = obs, 30:0 = datai).
- `clear`  in  1  discard the loaded program (count := 0); honoured in IDLE/DONE only.
- `start`  in  1  begin replay; honoured in IDLE/DONE with count > 0.
- `stop`  in  1  abort replay; honoured in RUN.
- `loop_en`  in  1  wrap to word 0 after the last word instead of finishing.
- `datai`  out  31  stimulus data to the DUT.
- `obs`  out  1  observation strobe to the DUT.
- `stim_valid`  out  1  `datai`/`obs` carry a replayed word this cycle.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `issued`  out  32  words issued since the last start; wraps modulo 2^32.

## Operation
- States: IDLE, RUN, DONE.
- Load (IDLE or DONE): `load_ready` = !start && count < DEPTH. A handshake writes ram[count], then count++. At count == DEPTH, `load_ready` = 0 and further words are not written.
- IDLE/DONE + `clear`: count := 0. `clear` has priority over a load in the same cycle. `start` together with `clear`: `clear` wins and `start` is ignored.
- IDLE/DONE + `start` + count > 0 → RUN. Set rd_ptr := 0 and issued := 0. A load in that cycle is refused (`load_ready` low).
- `start` with count == 0: ignored; the state is unchanged.
- RUN, each cycle:
  - Output regs := ram[rd_ptr]; `stim_valid` := 1; issued++.
  - If rd_ptr == count-1: with `loop_en`, rd_ptr := 0 and stay in RUN; otherwise → DONE.
  - Else rd_ptr++.
- RUN + `stop` → IDLE. No word is issued that cycle. `stop` overrides the last-word transition.
- DONE is sticky until `start`, `clear` (→ IDLE), or reset. `clear` in DONE also → IDLE.
- Whenever a cycle issues no word, `datai` = 0, `obs` = 0, `stim_valid` = 0.
- `issued` holds its value outside RUN.

## Timing
- Reset values: `datai` 0, `obs` 0, `stim_valid` 0, `busy` 0, `done` 0, `issued` 0, `load_ready` 1, state IDLE, count 0. RAM contents are not cleared.
- Reset asserted mid-RUN: outputs are forced to reset values asynchronously. After release: IDLE with count 0, so a program must be reloaded.
- Latency: `start` sampled at edge N → `busy` high after N. ram[0] appears on `datai`/`obs` after edge N+1; word k appears after edge N+1+k.
- Non-loop replay of count words: `stim_valid` is high for exactly count cycles, then `done` rises on the same edge that `stim_valid` falls.
- Loop mode: ram[count-1] is followed immediately by ram[0]. No bubble.
- Load of word k to issue of word k: at least 2 edges.
- RAM: one write port, one synchronous read port. The read address is presented combinationally from the next-state rd_ptr.

## Structure
- Package `conc_stim_pkg`:
  - state enum `stim_state_t` {IDLE, RUN, DONE};
  - `STIM_W` = 32, `OBS_BIT` = 31;
  - default `DEPTH`/`AW`.
- Sub-module `conc_stim_ram`: DEPTH×32, 1W/1R synchronous, no reset.
- Top `conc_stim_sequencer` contains:
  - the FSM;
  - the load counter, rd_ptr and issued counter;
  - the output registers.

## Test plan
- Load 3 words {32'h8000_0001, 32'h0000_0002, 32'h7FFF_FFFF}, `start` → `stim_valid` for 3 cycles. (`obs`,`datai`) sequence (1,1), (0,2), (0,31'h7FFF_FFFF); then `done` = 1, `issued` = 3, outputs 0.
- Same program with `loop_en` = 1, run 7 cycles then `stop` → words 0,1,2,0,1,2,0. Next cycle `stim_valid` = 0, state IDLE, `issued` = 7.
- Load 501 words → `load_ready` = 0 after the 501st. Word 502 is not written. Replay ends on word 500 and `done` rises.
- `start` with count 0 → no state change. `clear` + `start` in DONE → IDLE with count 0, no replay.
- Assert `reset` asynchronously mid-RUN at word 1 → `datai`/`obs`/`stim_valid`/`busy` drop to 0 before the next edge. After release, `start` is ignored until a reload.
- `load_valid` and `start` in the same IDLE cycle with count 2 → `load_ready` = 0, the word is not stored, replay issues exactly 2 words.
